audio_dac_tx: RTL and testbench
===============================

# audio_dac_tx

Consumer side of the audio sample write interface. Accepts 24-bit samples from sound-effect players through the `write`/`write_ready` handshake, buffers them in a small FIFO and serializes them as I2S onto the codec DAC data pin. Bit clock and LR clock come from the codec, which is clock master; each sample is played on both channels. Sits between the sfx players and the codec pins, and sets the playback rate by back-pressure.

## Interface

**Parameters**

- `W`, default 24: sample width in bits.
- `DEPTH`, default 8: FIFO depth in samples. Must be a power of 2, 2 or greater.

**Ports**

- `clk` in 1: 50 MHz system clock.
- `reset` in 1: reset, synchronous, active-high. Clock is `clk`.
- `write` in 1: producer offers `write_d` this cycle.
- `write_d` in W: sample, two's complement.
- `write_ready` out 1: FIFO can accept a sample this cycle.
- `aud_bclk` in 1: codec bit clock, asynchronous to `clk`.
- `aud_daclrck` in 1: codec DAC LR clock, asynchronous. Low selects left, high selects right.
- `aud_dacdat` out 1: serial DAC data, registered.
- `underflow` out 1: one-cycle pulse when a left frame starts with the FIFO empty.

## Operation

**Synchronizers and edge detection**

- `aud_bclk` and `aud_daclrck` each pass through a 2-flop synchronizer, giving `bclk_s` and `lrck_s`.
- `bfall` = `bclk_s` was 1 last cycle and is 0 now.
- On every `bfall`, `lrck_prev` takes the value of `lrck_s`.
- `lr_edge` = `bfall` and (`lrck_s` != `lrck_prev`).

**FIFO**

- DEPTH entries, with read and write pointers plus a count.
- `write_ready` = not full, and low while `reset` is asserted.
- A push happens only when `write` and `write_ready` are both high. A `write` while not ready is ignored: no data change, no error.
- A push and a pop in the same cycle leave the count unchanged. When full, `write_ready` is already low, so no push occurs in that cycle.
- There is no bypass. A pop in the same cycle as a push into an empty FIFO sees empty.

**Serializer state machine**

- `S_IDLE`: `aud_dacdat` = 0.
  - On `lr_edge`, load the shift register and go to `S_DELAY`.
- `S_DELAY`: the I2S one-bit slot, `aud_dacdat` = 0.
  - On the next `bfall`, go to `S_SHIFT` with bit counter = W-1.
- `S_SHIFT`: `aud_dacdat` = shift register MSB.
  - On each `bfall`, shift left by 1 and decrement the counter.
  - On the `bfall` when the counter is 0, go to `S_IDLE`.
- An `lr_edge` in any state reloads the shift register and goes to `S_DELAY`, truncating any unfinished word.

**Load source**

- Left edge (`lrck_s` = 0):
  - If the FIFO is non-empty: pop the head into both the shift register and `hold`.
  - If empty: load 0 into both and pulse `underflow`.
- Right edge (`lrck_s` = 1): shift register takes `hold`. No pop.

**Reset**

- Clears the FIFO, pointers, `hold`, shift register, synchronizers and `lrck_prev` to 0.
- State goes to `S_IDLE`.
- `aud_dacdat` = 0, `underflow` = 0, `write_ready` = 0.
- Mid-frame reset discards the word in flight and all buffered samples. Output stays 0 until the first `lr_edge` after reset.

## Timing

- `write_ready` is high on the first cycle after reset deasserts.
- A push is visible in the count the next cycle. `write_ready` falls the cycle after the DEPTH-th push.
- Pin to internal edge latency: 2 clk for synchronization plus 1 clk for detection.
- `aud_dacdat` is registered. It changes 1 clk after the `bfall` that advances it, which is no more than 4 clk after the physical BCLK fall. The codec samples on the BCLK rise, so this requires BCLK period ≥ 10 clk (true for 3.072 MHz BCLK at 50 MHz).
- The pop, the `hold` update and `underflow` all occur in the `lr_edge` cycle. `write_ready` rises the next cycle.
- `underflow` lasts exactly 1 cycle per starved frame.
- One sample is consumed per LRCK period. At 48 kHz, a producer that is always offering sees `write_ready` pulse once per 1042 cycles after the FIFO fills.

## Test plan

1. **Reset and first writes.** Assert reset for 3 cycles, then hold `write`=1 with `write_d` = 1, 2, …, 10.
   - `write_ready` is 0 during reset and 1 after.
   - Exactly 8 samples (1..8) are accepted, and `write_ready` is 0 from the 9th cycle on.
2. **Serialization.** Push 0xA5F00F, then drive BCLK at 25 clk/bit and LRCK at 64 bits/frame, low first.
   - Left slot: a 0 delay bit, then bits 1010 0101 1111 0000 0000 1111 MSB first, then 0s.
   - Right slot carries the identical word.
3. **Underflow.** Run LRCK with the FIFO empty.
   - `underflow` pulses once per LRCK falling edge.
   - `aud_dacdat` stays 0 throughout.
   - The first sample pushed afterwards plays on the next left frame.
4. **Order and rate.** Push 0x000001, 0x7FFFFF, 0x800000.
   - Three consecutive frames play them in order, each on both channels.
   - `write_ready` re-asserts exactly once per frame.
5. **Full plus pop.** Fill to 8, then hold `write`=1 across a left edge.
   - The pop occurs and `write_ready` goes high the next cycle.
   - A push lands 1 cycle after the pop, and the count returns to 8.
6. **Mid-word reset.** Assert reset at bit 10 of a left word.
   - `aud_dacdat` is 0 on the next cycle and stays 0 until the next `lr_edge`.
   - The FIFO is empty, and the first post-reset left frame pulses `underflow`.

Source files
------------

// File: rtl/audio_dac_tx_if.sv
// Sample write handshake between sound-effect players and the I2S DAC transmitter.
// The producer holds write high with write_d; a transfer happens on a cycle with write_ready high.
interface audio_dac_tx_if #(
  parameter int unsigned W = 24
) ();
  logic         write;
  logic [W-1:0] write_d;
  logic         write_ready;

  modport master (
    output write,
    output write_d,
    input  write_ready
  );

  modport slave (
    input  write,
    input  write_d,
    output write_ready
  );
endinterface

// File: rtl/audio_dac_tx.sv
// I2S DAC transmitter: buffers producer samples in a FIFO and shifts them out on the codec's
// asynchronous BCLK/LRCK, playing each sample on both channels.
module audio_dac_tx #(
  parameter int unsigned W     = 24,
  parameter int unsigned DEPTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  audio_dac_tx_if.slave wr,
  input  logic          aud_bclk,
  input  logic          aud_daclrck,
  output logic          aud_dacdat,
  output logic          underflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {StIdle, StDelay, StShift} state_e;

  // Codec clock synchronizers and edge history
  logic bclk_meta_q, bclk_meta_d, bclk_s_q, bclk_s_d, bclk_prev_q, bclk_prev_d;
  logic lrck_meta_q, lrck_meta_d, lrck_s_q, lrck_s_d, lrck_prev_q, lrck_prev_d;

  // FIFO storage
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;

  // Serializer
  state_e        state_q, state_d;
  logic [W-1:0]  shift_q, shift_d;
  logic [W-1:0]  hold_q, hold_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dacdat_q, dacdat_d;

  logic         bfall, lr_edge, left_edge;
  logic         empty, full, ready, push, pop;
  logic [W-1:0] head;

  assign bfall     = bclk_prev_q & ~bclk_s_q;
  assign lr_edge   = bfall & (lrck_s_q != lrck_prev_q);
  assign left_edge = lr_edge & ~lrck_s_q;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW + 1)'(DEPTH));
  assign ready = ~reset & ~full;
  assign push  = wr.write & ready;
  // No bypass: a sample pushed this cycle is not visible to a pop in the same cycle.
  assign pop   = left_edge & ~empty;
  assign head  = empty ? '0 : mem_q[rptr_q];

  assign wr.write_ready = ready;
  assign underflow      = ~reset & left_edge & empty;
  assign aud_dacdat     = dacdat_q;

  always_comb begin
    bclk_meta_d = aud_bclk;
    bclk_s_d    = bclk_meta_q;
    bclk_prev_d = bclk_s_q;
    lrck_meta_d = aud_daclrck;
    lrck_s_d    = lrck_meta_q;
    lrck_prev_d = bfall ? lrck_s_q : lrck_prev_q;

    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
    if (push) begin
      mem_d[wptr_q] = wr.write_d;
      wptr_d        = wptr_q + AW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
    end

    state_d = state_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
      end
      StDelay: begin
        if (bfall) begin
          state_d = StShift;
          cnt_d   = CW'(W - 1);
        end
      end
      StShift: begin
        if (bfall) begin
          if (cnt_q == '0) begin
            state_d = StIdle;
          end else begin
            shift_d = shift_q << 1;
            cnt_d   = cnt_q - CW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A new LR edge always wins, truncating any word still being shifted.
    if (lr_edge) begin
      state_d = StDelay;
      if (lrck_s_q) begin
        shift_d = hold_q;
      end else begin
        shift_d = head;
        hold_d  = head;
      end
    end

    dacdat_d = (state_d == StShift) ? shift_d[W-1] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_meta_q <= 1'b0;
      bclk_s_q    <= 1'b0;
      bclk_prev_q <= 1'b0;
      lrck_meta_q <= 1'b0;
      lrck_s_q    <= 1'b0;
      lrck_prev_q <= 1'b0;
      mem_q       <= '{default: '0};
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      state_q     <= StIdle;
      shift_q     <= '0;
      hold_q      <= '0;
      cnt_q       <= '0;
      dacdat_q    <= 1'b0;
    end else begin
      bclk_meta_q <= bclk_meta_d;
      bclk_s_q    <= bclk_s_d;
      bclk_prev_q <= bclk_prev_d;
      lrck_meta_q <= lrck_meta_d;
      lrck_s_q    <= lrck_s_d;
      lrck_prev_q <= lrck_prev_d;
      mem_q       <= mem_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      cnt_q       <= cnt_d;
      dacdat_q    <= dacdat_d;
    end
  end

endmodule

// File: tb/tb_audio_dac_tx.sv
// Bench for audio_dac_tx: acts as codec (BCLK/LRCK master, samples data on BCLK rise) and as
// producer, decoding each I2S slot and comparing it to a queue model of the sample stream.
module tb_audio_dac_tx;
  localparam int unsigned W     = 24;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  logic aud_bclk, aud_daclrck, aud_dacdat, underflow;

  audio_dac_tx_if #(.W(W)) bus ();

  audio_dac_tx #(.W(W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr         (bus),
    .aud_bclk   (aud_bclk),
    .aud_daclrck(aud_daclrck),
    .aud_dacdat (aud_dacdat),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;
  int uf_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (underflow === 1'b1) uf_cnt <= uf_cnt + 1;

  // Model: samples accepted but not yet played, and the last left-channel word.
  logic [W-1:0] model_q[$];
  logic [W-1:0] model_hold;
  bit           need_pre;
  int           left_fall_cyc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One BCLK period of 25 clk: fall (with LRCK update), rise after 12 clk where data is sampled.
  task automatic codec_bit(input logic lr, output logic sampled, output int fall_c);
    tick();
    aud_bclk    = 1'b0;
    aud_daclrck = lr;
    fall_c      = cyc;
    repeat (12) tick();
    aud_bclk = 1'b1;
    sampled  = aud_dacdat;
    repeat (12) tick();
  endtask

  task automatic play_slot(input logic lr, input logic [W-1:0] exp_w, input string name);
    logic [31:0] got, exp32;
    logic        b;
    int          fc;
    for (int i = 0; i < 32; i++) begin
      codec_bit(lr, b, fc);
      if (i == 0 && !lr) left_fall_cyc = fc;
      got[31-i] = b;
    end
    exp32 = {1'b0, exp_w, 7'b0};
    checks++;
    if (got !== exp32) $display("FAIL %s: slot bits got %h want %h", name, got, exp32);
    else passes++;
  endtask

  task automatic play_frame(input string name);
    logic [W-1:0] exp_l;
    int           uf0;
    int           starve;
    if (need_pre) begin
      play_slot(1'b1, model_hold, {name, "/pre"});
      need_pre = 1'b0;
    end
    uf0 = uf_cnt;
    if (model_q.size() > 0) begin
      exp_l  = model_q.pop_front();
      starve = 0;
    end else begin
      exp_l  = '0;
      starve = 1;
    end
    model_hold = exp_l;
    play_slot(1'b0, exp_l, {name, "/L"});
    play_slot(1'b1, model_hold, {name, "/R"});
    checks++;
    if (uf_cnt - uf0 != starve)
      $display("FAIL %s/underflow: pulses got %0d want %0d", name, uf_cnt - uf0, starve);
    else passes++;
  endtask

  task automatic push_one(input logic [W-1:0] d);
    bit done = 1'b0;
    bus.write   = 1'b1;
    bus.write_d = d;
    for (int t = 0; t < 4000 && !done; t++) begin
      @(negedge clk);
      if (bus.write_ready === 1'b1) begin
        model_q.push_back(d);
        done = 1'b1;
      end
      tick();
    end
    bus.write = 1'b0;
    if (!done) begin
      checks++;
      $display("FAIL push_timeout: write_ready got 0 want 1 within 4000 cycles");
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if (bus.write_ready !== 1'b0)
        $display("FAIL reset_ready: write_ready got %b want 0", bus.write_ready);
      else passes++;
      if (i > 0) begin
        checks++;
        if ({aud_dacdat, underflow} !== 2'b00)
          $display("FAIL reset_outs: dacdat,underflow got %b want 00", {aud_dacdat, underflow});
        else passes++;
      end
      tick();
    end
    reset = 1'b0;
    model_q.delete();
    model_hold = '0;
    need_pre   = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(3);
  endtask

  task automatic test_first_writes();
    logic exp_rdy;
    for (int k = 1; k <= 10; k++) begin
      bus.write   = 1'b1;
      bus.write_d = W'(k);
      @(negedge clk);
      exp_rdy = (k <= DEPTH);
      checks++;
      if (bus.write_ready !== exp_rdy)
        $display("FAIL first_ready[%0d]: write_ready got %b want %b", k, bus.write_ready, exp_rdy);
      else passes++;
      if (bus.write_ready === 1'b1) model_q.push_back(W'(k));
      tick();
    end
    bus.write = 1'b0;
    for (int i = 0; i <= DEPTH; i++) play_frame("first");
  endtask

  task automatic test_serialization();
    push_one(24'hA5F00F);
    play_frame("serial");
  endtask

  task automatic test_underflow();
    repeat (2) play_frame("uflow_empty");
    push_one(W'($urandom()));
    play_frame("uflow_refill");
    play_frame("uflow_again");
  endtask

  task automatic test_order();
    push_one(24'h000001);
    push_one(24'h7FFFFF);
    push_one(24'h800000);
    for (int i = 0; i < 3; i++) play_frame("order");
  endtask

  // Producer always offering while one frame plays on a full FIFO.
  task automatic frame_with_producer(input string name);
    int           rises    = 0;
    int           rise_cyc = -1;
    bit           done     = 1'b0;
    bit           pushed;
    logic [W-1:0] d;
    d = W'($urandom());
    fork
      begin
        play_frame(name);
        done = 1'b1;
      end
      begin
        bus.write   = 1'b1;
        bus.write_d = d;
        while (!done) begin
          pushed = 1'b0;
          @(negedge clk);
          if (bus.write_ready === 1'b1) begin
            rises++;
            if (rise_cyc < 0) rise_cyc = cyc;
            model_q.push_back(d);
            pushed = 1'b1;
          end
          tick();
          if (pushed) begin
            d           = W'($urandom());
            bus.write_d = d;
          end
        end
        bus.write = 1'b0;
      end
    join
    checks++;
    if (rises != 1) $display("FAIL %s/ready_pulses: got %0d want 1", name, rises);
    else passes++;
    checks++;
    if (rise_cyc - left_fall_cyc != 3)
      $display("FAIL %s/ready_latency: got %0d want 3", name, rise_cyc - left_fall_cyc);
    else passes++;
    @(negedge clk);
    checks++;
    if (bus.write_ready !== 1'b0)
      $display("FAIL %s/refilled: write_ready got %b want 0", name, bus.write_ready);
    else passes++;
    tick();
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < DEPTH; i++) push_one(W'($urandom()));
    @(negedge clk);
    checks++;
    if (bus.write_ready !== 1'b0)
      $display("FAIL full_ready: write_ready got %b want 0", bus.write_ready);
    else passes++;
    tick();
    for (int i = 0; i < 3; i++) frame_with_producer("fullpop");
    for (int i = 0; i <= DEPTH; i++) play_frame("fullpop_drain");
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] w;
    logic [31:0]  exp32;
    logic [10:0]  got_hi, exp_hi;
    logic [20:0]  got_lo;
    logic         b;
    int           fc, uf0;
    push_one(W'($urandom()));
    push_one(W'($urandom()));
    w          = model_q.pop_front();
    model_hold = w;
    exp32      = {1'b0, w, 7'b0};
    exp_hi     = exp32[31:21];
    for (int i = 0; i < 11; i++) begin
      codec_bit(1'b0, b, fc);
      got_hi[10-i] = b;
    end
    checks++;
    if (got_hi !== exp_hi) $display("FAIL midrst_head: bits got %h want %h", got_hi, exp_hi);
    else passes++;
    reset = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (aud_dacdat !== 1'b0) $display("FAIL midrst_dat: dacdat got %b want 0", aud_dacdat);
    else passes++;
    tick();
    reset = 1'b0;
    model_q.delete();
    model_hold = '0;
    uf0        = uf_cnt;
    for (int i = 0; i < 21; i++) begin
      codec_bit(1'b0, b, fc);
      got_lo[20-i] = b;
    end
    checks++;
    if (got_lo !== '0) $display("FAIL midrst_tail: bits got %h want 0", got_lo);
    else passes++;
    play_slot(1'b1, '0, "midrst/R");
    checks++;
    if (uf_cnt != uf0) $display("FAIL midrst_early_uflow: got %0d want 0", uf_cnt - uf0);
    else passes++;
    play_frame("midrst_after");
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 2; r++) begin
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) push_one(W'($urandom()));
      for (int i = 0; i <= n; i++) play_frame("random");
    end
  endtask

  initial begin
    reset       = 1'b1;
    bus.write   = 1'b0;
    bus.write_d = '0;
    aud_bclk    = 1'b1;
    aud_daclrck = 1'b1;
    model_hold  = '0;
    need_pre    = 1'b1;
    test_reset();
    test_first_writes();
    test_serialization();
    test_underflow();
    test_order();
    test_full_pop();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
